conv_window5x5: RTL and testbench

Reader side of the 5-row line buffer chain. It consumes one 5-pixel column per enable strobe, assembles a 5x5 sliding window, and tracks raster position. It flags each window that lies fully inside the image and drives it to the conv5x5 MAC stage.

---
 rtl/conv_window5x5.sv | 146 ++++++++++++++
 tb/tb_conv_window5x5.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window5x5.sv
// conv_window5x5: reader side of the 5-row line buffer chain.
// Accepts one 5-pixel column per en strobe, shifts it into a 5x5 window,
// tracks the raster position of the incoming pixel and flags windows that
// lie completely inside the image. All outputs are registered and update
// together one cycle after the accepting en cycle.
//
// Handshake: en is a one-way valid with no back-pressure. A column is
// consumed on every rising edge where en=1 and clr=0. win_valid is a
// one-cycle pulse; window/out_row/out_col stay stable until the next
// accepted column, so a consumer may sample them whenever win_valid=1.
module conv_window5x5 #(
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int BIT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [BIT_WIDTH-1:0]     r0,
  input  logic [BIT_WIDTH-1:0]     r1,
  input  logic [BIT_WIDTH-1:0]     r2,
  input  logic [BIT_WIDTH-1:0]     r3,
  input  logic [BIT_WIDTH-1:0]     r4,
  output logic [25*BIT_WIDTH-1:0]  window,
  output logic                     win_valid,
  output logic [7:0]               out_row,
  output logic [7:0]               out_col,
  output logic                     frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_FOUR = CW'(4);
  localparam logic [RW-1:0] ROW_FOUR = RW'(4);

  logic [BIT_WIDTH-1:0] win_q [5][5];
  logic [BIT_WIDTH-1:0] col_in [5];

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          win_valid_q;
  logic          frame_done_q;
  logic [7:0]    out_row_q;
  logic [7:0]    out_col_q;

  logic win_ok;
  logic at_col_end;
  logic at_row_end;

  // Window row 0 is the top (oldest row, r4); row 4 is the current row (r0).
  assign col_in[0] = r4;
  assign col_in[1] = r3;
  assign col_in[2] = r2;
  assign col_in[3] = r1;
  assign col_in[4] = r0;

  assign win_ok     = (col_cnt_q >= COL_FOUR) && (row_cnt_q >= ROW_FOUR);
  assign at_col_end = (col_cnt_q == COL_LAST);
  assign at_row_end = (row_cnt_q == ROW_LAST);

  // Raster position of the next pixel: clr restarts, en advances col then row.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (clr) begin
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else if (en) begin
      if (at_col_end) begin
        col_cnt_d = '0;
        row_cnt_d = at_row_end ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end
  end

  // Position counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Window shift register: every row shifts left, new column enters at c=4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (en && !clr) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][4] <= col_in[r];
      end
    end
  end

  // Valid/done pulses and the top-left coordinate of the presented window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else if (clr) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (en) begin
      win_valid_q  <= win_ok;
      frame_done_q <= at_col_end && at_row_end;
      if (win_ok) begin
        out_row_q <= 8'(row_cnt_q - ROW_FOUR);
        out_col_q <= 8'(col_cnt_q - COL_FOUR);
      end
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end
  end

  // Flatten the window: element [r][c] at (r*5+c)*BIT_WIDTH.
  for (genvar gr = 0; gr < 5; gr++) begin : g_row
    for (genvar gc = 0; gc < 5; gc++) begin : g_col
      assign window[(gr*5+gc)*BIT_WIDTH +: BIT_WIDTH] = win_q[gr][gc];
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;

endmodule

// File: tb/tb_conv_window5x5.sv
// Self-checking bench for conv_window5x5 at default parameters.
// Pixels follow p(y,x) = (y*COLS+x) mod 256, with r_k = p(y-k,x).
module tb_conv_window5x5;

  localparam int COLS = 28;
  localparam int ROWS = 28;
  localparam int W    = 8;
  localparam int NPIX = COLS * ROWS;

  logic           clk;
  logic           rst;
  logic           en;
  logic           clr;
  logic [W-1:0]   r0, r1, r2, r3, r4;
  logic [25*W-1:0] window;
  logic           win_valid;
  logic [7:0]     out_row;
  logic [7:0]     out_col;
  logic           frame_done;

  int n_checks;
  int n_errors;
  int valid_cnt;
  int done_cnt;
  int exp_row;
  int exp_col;
  bit last_valid;

  conv_window5x5 #(.COLS(COLS), .ROWS(ROWS), .BIT_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .r0         (r0),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .r4         (r4),
    .window     (window),
    .win_valid  (win_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pix(input int y, input int x);
    if (y < 0) return '0;
    return W'((y * COLS + x) % 256);
  endfunction

  // Expected window whose top-left pixel is (row_top, col_left).
  function automatic logic [199:0] exp_window(input int row_top, input int col_left);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w[(r*5+c)*W +: W] = pix(row_top + r, col_left + c);
      end
    end
    return w;
  endfunction

  task automatic drive_col(input int y, input int x);
    r0 = pix(y, x);
    r1 = pix(y - 1, x);
    r2 = pix(y - 2, x);
    r3 = pix(y - 3, x);
    r4 = pix(y - 4, x);
  endtask

  // Accept pixel (y,x) and check the registered result one cycle later.
  task automatic send(input int y, input int x);
    bit ev;
    en  = 1'b1;
    clr = 1'b0;
    drive_col(y, x);
    @(posedge clk);
    #1;
    ev = (x >= 4) && (y >= 4);
    check("win_valid", win_valid, ev);
    check("frame_done", frame_done, (x == COLS - 1) && (y == ROWS - 1));
    if (ev) begin
      exp_row = y - 4;
      exp_col = x - 4;
    end
    check("out_row", out_row, exp_row);
    check("out_col", out_col, exp_col);
    if (ev) check("window", window, exp_window(exp_row, exp_col));
    last_valid = ev;
    if (win_valid)  valid_cnt++;
    if (frame_done) done_cnt++;
  endtask

  // One idle cycle: everything holds, pulses drop.
  task automatic idle_cycle();
    en = 1'b0;
    @(posedge clk);
    #1;
    check("idle_valid", win_valid, 1'b0);
    check("idle_done", frame_done, 1'b0);
    check("idle_out_row", out_row, exp_row);
    check("idle_out_col", out_col, exp_col);
    if (last_valid) check("idle_window", window, exp_window(exp_row, exp_col));
  endtask

  // Raster stream from (0,0); optional 3-cycle gap after pixel (6,10).
  task automatic stream(input int n_pix, input bit gaps);
    for (int i = 0; i < n_pix; i++) begin
      send((i / COLS) % ROWS, i % COLS);
      if (gaps && ((i % NPIX) == 6 * COLS + 10)) begin
        repeat (3) idle_cycle();
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    valid_cnt  = 0;
    done_cnt   = 0;
    exp_row    = 0;
    exp_col    = 0;
    last_valid = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0;

    // Reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("rst_window", window, '0);
    check("rst_valid", win_valid, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_out_row", out_row, 8'd0);
    check("rst_out_col", out_col, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Two back-to-back frames, continuous en
    stream(2 * NPIX, 1'b0);
    check("b2b_valid_count", valid_cnt, 1152);
    check("b2b_done_count", done_cnt, 2);

    // Frame with an en gap after pixel (6,10)
    valid_cnt = 0;
    done_cnt  = 0;
    stream(NPIX, 1'b1);
    check("gap_valid_count", valid_cnt, 576);
    check("gap_done_count", done_cnt, 1);

    // clr together with en at pixel (10,10): pixel dropped, counters restart
    stream(10 * COLS + 10, 1'b0);
    en  = 1'b1;
    clr = 1'b1;
    drive_col(10, 10);
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_valid", win_valid, 1'b0);
    check("clr_done", frame_done, 1'b0);
    check("clr_out_row", out_row, exp_row);
    check("clr_out_col", out_col, exp_col);
    check("clr_window", window, exp_window(exp_row, exp_col));
    valid_cnt = 0;
    done_cnt  = 0;
    stream(NPIX, 1'b0);
    check("clr_valid_count", valid_cnt, 576);
    check("clr_done_count", done_cnt, 1);

    // Asynchronous reset mid-frame, checked before any clock edge
    stream(5 * COLS + 8, 1'b0);
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_window", window, '0);
    check("mid_rst_valid", win_valid, 1'b0);
    check("mid_rst_done", frame_done, 1'b0);
    check("mid_rst_out_row", out_row, 8'd0);
    check("mid_rst_out_col", out_col, 8'd0);
    exp_row    = 0;
    exp_col    = 0;
    last_valid = 1'b0;
    #3;
    rst = 1'b1;
    valid_cnt = 0;
    done_cnt  = 0;
    stream(NPIX, 1'b0);
    check("post_rst_valid_count", valid_cnt, 576);
    check("post_rst_done_count", done_cnt, 1);

    en = 1'b0;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
